mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch side and its load/store side.
- Sits between the core (pc/instr/ihit and aluout/writedata/memwrite/dcen/readdata/dhit) and the memory.
- Serialises requests with one outstanding transaction, round-robin on contention, and a watchdog on stalled memory responses.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and load/store.
// One outstanding transaction, round-robin on contention, sticky watchdog on stalled responses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              ihit_o,
  output logic [DATA_W-1:0] instr_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              dhit_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e            state_q, state_d;
  logic              last_d_q;  // 1 when the most recent grant went to the data side
  logic [CntW-1:0]   wait_q;
  logic              err_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              grant_i, grant_d;

  // Round-robin: on contention the side that did not win last time is granted.
  always_comb begin
    grant_i = i_req_i & (~d_req_i | last_d_q);
    grant_d = d_req_i & (~i_req_i | ~last_d_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d = StIBusy;
        end else if (grant_d) begin
          state_d = StDBusy;
        end
      end
      StIBusy, StDBusy: begin
        if (mem_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ihit_o = 1'b0;
    dhit_o = 1'b0;
    unique case (state_q)
      StIBusy: ihit_o = mem_ready_i;
      StDBusy: dhit_o = mem_ready_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_d_q    <= 1'b1;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else if (state_q == StIdle) begin
      if (grant_i) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= i_addr_i;
        mem_wdata_q <= '0;
        last_d_q    <= 1'b0;
        wait_q      <= '0;
      end else if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we_i;
        mem_addr_q  <= d_addr_i;
        mem_wdata_q <= d_wdata_i;
        last_d_q    <= 1'b1;
        wait_q      <= '0;
      end
    end else if (mem_ready_i) begin
      mem_req_q <= 1'b0;
    end else begin
      if (wait_q != CntMax) begin
        wait_q <= wait_q + 1'b1;
      end
      // This stalled cycle is the TIMEOUT-th one; the transaction keeps waiting.
      if (wait_q >= CntLast) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign instr_o     = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              i_req_i = 1'b0;
  logic [ADDR_W-1:0] i_addr_i = '0;
  logic              ihit_o;
  logic [DATA_W-1:0] instr_o;
  logic              d_req_i = 1'b0;
  logic              d_we_i = 1'b0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [DATA_W-1:0] d_wdata_i = '0;
  logic              dhit_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              err_o;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .ihit_o     (ihit_o),
    .instr_o    (instr_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .dhit_o     (dhit_o),
    .d_rdata_o  (d_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit ihit_seen = 1'b0;
  bit dhit_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the memory, what it was asked for, how long it has stalled.
  int                owner = 0;  // 0 none, 1 fetch, 2 data
  logic [ADDR_W-1:0] tx_addr = '0;
  logic              tx_we = 1'b0;
  logic [DATA_W-1:0] tx_wdata = '0;
  int                stalled = 0;
  bit                err_m = 1'b0;
  bit                i_turn = 1'b1;  // fetch wins the next contention

  always @(posedge clk) begin
    if (rst_i) begin
      owner = 0; tx_addr = '0; tx_we = 1'b0; tx_wdata = '0;
      stalled = 0; err_m = 1'b0; i_turn = 1'b1;
    end else if (owner == 0) begin
      if (i_req_i && (!d_req_i || i_turn)) begin
        owner = 1; tx_addr = i_addr_i; tx_we = 1'b0; tx_wdata = '0;
        stalled = 0; i_turn = 1'b0;
      end else if (d_req_i) begin
        owner = 2; tx_addr = d_addr_i; tx_we = d_we_i; tx_wdata = d_wdata_i;
        stalled = 0; i_turn = 1'b1;
      end
    end else if (mem_ready_i) begin
      owner = 0;
    end else begin
      stalled++;
      if (stalled >= TIMEOUT) err_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req_o, owner != 0);
      check("mem_we", mem_we_o, tx_we);
      check("mem_addr", mem_addr_o, tx_addr);
      check("mem_wdata", mem_wdata_o, tx_wdata);
      check("ihit", ihit_o, (owner == 1) && mem_ready_i);
      check("dhit", dhit_o, (owner == 2) && mem_ready_i);
      check("err", err_o, err_m);
      check("hits_exclusive", ihit_o & dhit_o, 1'b0);
      if (ihit_o) check("instr", instr_o, mem_rdata_i);
      if (dhit_o) check("d_rdata", d_rdata_o, mem_rdata_i);
    end
    ihit_seen = ihit_o;
    dhit_seen = dhit_o;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  int hold_off = 0;

  initial begin
    repeat (3) step();
    rst_i = 1'b0;
    chk_en = 1'b1;
    look();
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);

    // Single fetch, memory always ready.
    step();
    i_req_i = 1'b1; i_addr_i = 32'h0000_0040; mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    step();
    look();
    check("fetch_req", mem_req_o, 1'b1);
    check("fetch_addr", mem_addr_o, 32'h40);
    check("fetch_we", mem_we_o, 1'b0);
    check("fetch_hit", ihit_o, 1'b1);
    check("fetch_instr", instr_o, 32'h1234_5678);
    step();
    i_req_i = 1'b0;
    look();
    check("fetch_req_drop", mem_req_o, 1'b0);

    // Store completing on the third busy cycle.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF;
    mem_ready_i = 1'b0;
    step();
    look();
    check("st_wdata1", mem_wdata_o, 32'hDEAD_BEEF);
    check("st_hit1", dhit_o, 1'b0);
    step();
    look();
    check("st_hit2", dhit_o, 1'b0);
    step();
    mem_ready_i = 1'b1;
    look();
    check("st_hit3", dhit_o, 1'b1);
    check("st_wdata3", mem_wdata_o, 32'hDEAD_BEEF);
    check("st_err", err_o, 1'b0);
    step();
    d_req_i = 1'b0; d_we_i = 1'b0;
    look();
    check("st_done", mem_req_o, 1'b0);

    // Both sides requesting every cycle after reset: I, idle, D, idle, ...
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 32'h80; d_addr_i = 32'h200;
    for (int k = 0; k < 8; k++) begin
      step();
      look();
      check("rr_ihit", ihit_o, (k % 4) == 0);
      check("rr_dhit", dhit_o, (k % 4) == 2);
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    step();
    step();

    // Fetch dropped while busy still completes; nothing granted afterwards.
    i_req_i = 1'b1; i_addr_i = 32'hC0; mem_ready_i = 1'b0;
    step();
    i_req_i = 1'b0;
    look();
    check("drop_busy_req", mem_req_o, 1'b1);
    step();
    mem_ready_i = 1'b1;
    look();
    check("drop_hit", ihit_o, 1'b1);
    step();
    step();
    look();
    check("drop_no_grant", mem_req_o, 1'b0);

    // Watchdog with TIMEOUT=4.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; mem_ready_i = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      look();
      check("wd_err_low", err_o, 1'b0);
      step();
    end
    look();
    check("wd_err_set", err_o, 1'b1);
    step();
    step();
    mem_ready_i = 1'b1;
    look();
    check("wd_late_hit", dhit_o, 1'b1);
    check("wd_err_sticky", err_o, 1'b1);
    step();
    d_req_i = 1'b0; mem_ready_i = 1'b0;
    look();
    check("wd_err_held", err_o, 1'b1);

    // Reset during the second D_BUSY cycle abandons the store.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h400; d_wdata_i = 32'h5555_AAAA;
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; mem_ready_i = 1'b1; i_req_i = 1'b1; i_addr_i = 32'h500;
    look();
    check("rst_busy_req", mem_req_o, 1'b0);
    check("rst_busy_dhit", dhit_o, 1'b0);
    check("rst_busy_err", err_o, 1'b0);
    step();
    look();
    check("rst_first_i", ihit_o, 1'b1);
    check("rst_first_addr", mem_addr_o, 32'h500);
    step();
    i_req_i = 1'b0; d_req_i = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_i = ($urandom_range(0, 299) == 0);
      if (i_req_i && (ihit_seen || $urandom_range(0, 63) == 0)) begin
        i_req_i = 1'b0;
      end else if (!i_req_i && $urandom_range(0, 2) == 0) begin
        i_req_i = 1'b1; i_addr_i = $urandom;
      end
      if (d_req_i && (dhit_seen || $urandom_range(0, 63) == 0)) begin
        d_req_i = 1'b0;
      end else if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1'b1; d_we_i = $urandom_range(0, 1) == 1;
        d_addr_i = $urandom; d_wdata_i = $urandom;
      end
      if (hold_off == 0 && $urandom_range(0, 99) == 0) hold_off = $urandom_range(3, 8);
      if (hold_off > 0) begin
        hold_off--;
        mem_ready_i = 1'b0;
      end else begin
        mem_ready_i = ($urandom_range(0, 3) != 0);
      end
      mem_rdata_i = $urandom;
    end
    rst_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
    step();
    look();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
